// File: rtl/program_loader_if.sv
// Byte-stream handshake between a program source and the loader.
// A byte moves on a rising clock edge when rxValid and rxReady are both 1.
interface program_loader_if;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;

  // Byte source side
  modport master (output rxData, output rxValid, input rxReady);
  // Loader side
  modport slave  (input rxData, input rxValid, output rxReady);
endinterface

// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream and assembles 16-bit words,
// high byte first. Each word is written to consecutive instruction-memory
// addresses. The frame is then checked against an XOR checksum, and the
// processor is held in cpuHold until the load completes.
// Frame: 0xA5, N, 2N data bytes, XOR of the data bytes.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 16,
  parameter int TIMEOUT    = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  program_loader_if.slave       rx,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [WORD_WIDTH-1:0] memData,
  output logic                  cpuHold,
  output logic                  loadDone,
  output logic                  loadError
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                state_q;
  logic [7:0]            count_q;
  logic [7:0]            wcnt_q;
  logic [7:0]            hi_q;
  logic [7:0]            csum_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  memWrite_q;
  logic [ADDR_WIDTH-1:0] memAddress_q;
  logic [WORD_WIDTH-1:0] memData_q;
  logic                  cpuHold_q;
  logic                  loadDone_q;
  logic                  loadError_q;

  logic accept;
  logic timed;
  logic tmo_hit;

  // Ready in every byte-consuming state; forced low while reset is held.
  assign rx.rxReady = reset_n &&
                      (state_q inside {S_IDLE, S_COUNT, S_HI, S_LO, S_CHECK});
  assign accept     = rx.rxValid && rx.rxReady;
  // States where the sender is inside a frame and must keep bytes coming.
  assign timed      = state_q inside {S_COUNT, S_HI, S_LO, S_CHECK};
  assign tmo_hit    = timed && !accept && (tmo_q == TMO_W'(TIMEOUT - 1));

  assign memWrite   = memWrite_q;
  assign memAddress = memAddress_q;
  assign memData    = memData_q;
  assign cpuHold    = cpuHold_q;
  assign loadDone   = loadDone_q;
  assign loadError  = loadError_q;

  // Loader FSM with registered outputs, checksum and inter-byte timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      wcnt_q       <= '0;
      hi_q         <= '0;
      csum_q       <= '0;
      tmo_q        <= '0;
      memWrite_q   <= 1'b0;
      memAddress_q <= '0;
      memData_q    <= '0;
      cpuHold_q    <= 1'b0;
      loadDone_q   <= 1'b0;
      loadError_q  <= 1'b0;
    end else begin
      memWrite_q <= 1'b0;
      loadDone_q <= 1'b0;

      // The idle counter only runs between bytes of a frame.
      if (timed && !accept) tmo_q <= tmo_q + TMO_W'(1);
      else                  tmo_q <= '0;

      case (state_q)
        S_IDLE: begin
          // Anything other than the start byte is dropped.
          if (accept && rx.rxData == 8'hA5) begin
            state_q      <= S_COUNT;
            cpuHold_q    <= 1'b1;
            loadError_q  <= 1'b0;
            csum_q       <= '0;
            memAddress_q <= '0;
            wcnt_q       <= '0;
          end
        end
        S_COUNT: begin
          if (accept) begin
            if (rx.rxData == 8'h00) begin
              state_q   <= S_IDLE;
              cpuHold_q <= 1'b0;
            end else begin
              count_q <= rx.rxData;
              state_q <= S_HI;
            end
          end
        end
        S_HI: begin
          if (accept) begin
            hi_q    <= rx.rxData;
            csum_q  <= csum_q ^ rx.rxData;
            state_q <= S_LO;
          end
        end
        S_LO: begin
          if (accept) begin
            memData_q  <= {hi_q, rx.rxData};
            csum_q     <= csum_q ^ rx.rxData;
            memWrite_q <= 1'b1;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Address wraps naturally; an oversize N overwrites earlier words.
          memAddress_q <= memAddress_q + ADDR_WIDTH'(1);
          wcnt_q       <= wcnt_q + 8'd1;
          state_q      <= ((wcnt_q + 8'd1) == count_q) ? S_CHECK : S_HI;
        end
        S_CHECK: begin
          if (accept) begin
            if (rx.rxData == csum_q) begin
              state_q    <= S_DONE;
              loadDone_q <= 1'b1;
            end else begin
              state_q     <= S_ERROR;
              loadError_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          cpuHold_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        S_ERROR: begin
          // Processor stays held; written words are left in place.
          loadError_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (tmo_hit) begin
        state_q     <= S_ERROR;
        loadError_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames, checksum error, garbage/N=0,
// continuous-valid backpressure, timeout, address wrap and mid-frame reset.
module tb_program_loader;
  localparam int AW  = 2;
  localparam int WW  = 16;
  localparam int TMO = 20;

  logic          clk;
  logic          reset_n;
  logic          memWrite;
  logic [AW-1:0] memAddress;
  logic [WW-1:0] memData;
  logic          cpuHold;
  logic          loadDone;
  logic          loadError;

  program_loader_if rx ();

  program_loader #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx.slave),
    .memWrite   (memWrite),
    .memAddress (memAddress),
    .memData    (memData),
    .cpuHold    (cpuHold),
    .loadDone   (loadDone),
    .loadError  (loadError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int fail_cnt = 0;
  int done_cnt = 0;
  int stall_cnt = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] ea[$];
  logic [31:0] ed[$];
  logic [7:0]  frame[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record writes, done pulses and stalled cycles mid-cycle.
  always @(negedge clk) begin
    if (memWrite === 1'b1) begin
      wa.push_back(32'(memAddress));
      wd.push_back(32'(memData));
      check("rdy_in_write", 32'(rx.rxReady), 32'd0);
    end
    if (loadDone === 1'b1) begin
      done_cnt++;
      check("rdy_in_done", 32'(rx.rxReady), 32'd0);
    end
    if (reset_n && rx.rxValid && !rx.rxReady) stall_cnt++;
  end

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    done_cnt  = 0;
    stall_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic rdy;
    bit   sent;
    n = 0;
    sent = 1'b0;
    rx.rxData  = b;
    rx.rxValid = 1'b1;
    while (!sent) begin
      @(negedge clk);
      rdy = rx.rxReady;
      @(posedge clk);
      #1;
      if (rdy) sent = 1'b1;
      else begin
        n++;
        if (n > 50) begin
          check("byte_accept_timeout", 32'd0, 32'd1);
          sent = 1'b1;
        end
      end
    end
  endtask

  // hold=1 keeps rxValid high for the whole frame (backpressure test).
  task automatic send_frame(input bit hold);
    foreach (frame[i]) begin
      send_byte(frame[i]);
      if (!hold) begin
        rx.rxValid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    rx.rxValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic expect_writes(input string tag);
    check({tag, "_nwr"}, 32'(wa.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      check({tag, "_addr"}, wa[i], ea[i]);
      check({tag, "_data"}, wd[i], ed[i]);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    rx.rxValid = 1'b0;
    rx.rxData  = 8'h00;
    #12;
    check("rst_rdy",  32'(rx.rxReady), 32'd0);
    check("rst_hold", 32'(cpuHold), 32'd0);
    check("rst_err",  32'(loadError), 32'd0);
    check("rst_wr",   32'(memWrite), 32'd0);
    check("rst_addr", 32'(memAddress), 32'd0);
    check("rst_data", 32'(memData), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_rdy", 32'(rx.rxReady), 32'd1);

    // Good load
    clear_mon();
    send_byte(8'hA5);
    rx.rxValid = 1'b0;
    #1;
    check("s1_hold_mid", 32'(cpuHold), 32'd1);
    frame = '{8'h03, 8'h01, 8'h23, 8'hA2, 8'h34, 8'h56, 8'h78, 8'h9A};
    send_frame(1'b0);
    ea = '{32'd0, 32'd1, 32'd2};
    ed = '{32'h0123, 32'hA234, 32'h5678};
    expect_writes("s1");
    check("s1_done", 32'(done_cnt), 32'd1);
    check("s1_hold", 32'(cpuHold), 32'd0);
    check("s1_err",  32'(loadError), 32'd0);

    // Bad checksum, then a good frame clears the error
    clear_mon();
    frame = '{8'hA5, 8'h03, 8'h01, 8'h23, 8'hA2, 8'h34, 8'h56, 8'h78, 8'h9B};
    send_frame(1'b0);
    expect_writes("s2");
    check("s2_done", 32'(done_cnt), 32'd0);
    check("s2_err",  32'(loadError), 32'd1);
    check("s2_hold", 32'(cpuHold), 32'd1);
    clear_mon();
    frame = '{8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h66};
    send_frame(1'b0);
    ea = '{32'd0};
    ed = '{32'hABCD};
    expect_writes("s2b");
    check("s2b_done", 32'(done_cnt), 32'd1);
    check("s2b_err",  32'(loadError), 32'd0);
    check("s2b_hold", 32'(cpuHold), 32'd0);

    // Garbage then empty frame
    clear_mon();
    frame = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00};
    send_frame(1'b0);
    check("s3_nwr",  32'(wa.size()), 32'd0);
    check("s3_done", 32'(done_cnt), 32'd0);
    check("s3_hold", 32'(cpuHold), 32'd0);

    // Continuous valid: stalls only in the three WRITE cycles
    clear_mon();
    frame = '{8'hA5, 8'h03, 8'h01, 8'h23, 8'hA2, 8'h34, 8'h56, 8'h78, 8'h9A};
    send_frame(1'b1);
    ea = '{32'd0, 32'd1, 32'd2};
    ed = '{32'h0123, 32'hA234, 32'h5678};
    expect_writes("s4");
    check("s4_stall", 32'(stall_cnt), 32'd3);
    check("s4_done",  32'(done_cnt), 32'd1);
    check("s4_hold",  32'(cpuHold), 32'd0);

    // Start byte value inside the data is ordinary data
    clear_mon();
    frame = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h00};
    send_frame(1'b0);
    ea = '{32'd0};
    ed = '{32'hA5A5};
    expect_writes("s5");
    check("s5_done", 32'(done_cnt), 32'd1);

    // Address wrap with 2-bit address: five words land at 0,1,2,3,0
    clear_mon();
    frame = '{8'hA5, 8'h05, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00,
              8'h40, 8'h00, 8'h50, 8'h00, 8'h10};
    send_frame(1'b0);
    ea = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    ed = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
    expect_writes("s6");
    check("s6_done", 32'(done_cnt), 32'd1);
    check("s6_err",  32'(loadError), 32'd0);

    // Timeout: error exactly TMO cycles after the last accepted byte
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    rx.rxValid = 1'b0;
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("s7_err_early", 32'(loadError), 32'd0);
    @(posedge clk);
    #1;
    check("s7_err", 32'(loadError), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("s7_nwr",  32'(wa.size()), 32'd0);
    check("s7_hold", 32'(cpuHold), 32'd1);
    check("s7_rdy",  32'(rx.rxReady), 32'd1);

    // Asynchronous reset in the WRITE cycle of a frame
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    rx.rxValid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("s8_wr",   32'(memWrite), 32'd0);
    check("s8_hold", 32'(cpuHold), 32'd0);
    check("s8_err",  32'(loadError), 32'd0);
    check("s8_addr", 32'(memAddress), 32'd0);
    check("s8_data", 32'(memData), 32'd0);
    check("s8_rdy",  32'(rx.rxReady), 32'd0);
    check("s8_done", 32'(loadDone), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
    frame = '{8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h66};
    send_frame(1'b0);
    ea = '{32'd0};
    ed = '{32'hABCD};
    expect_writes("s8b");
    check("s8b_done", 32'(done_cnt), 32'd1);
    check("s8b_hold", 32'(cpuHold), 32'd0);

    $display("%0d/%0d checks passed", chk_cnt - fail_cnt, chk_cnt);
    $finish;
  end

endmodule
